// File: rtl/alu_pkg.sv
// Shared types and function codes for the ALU issue stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOTA = 3'b101;
  localparam logic [2:0] ALU_PASS = 3'b110;
  localparam logic [2:0] ALU_NOTB = 3'b111;

  // One queued operation request.
  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        chain;
  } alu_cmd_t;

endpackage

// File: rtl/Alu32bit.sv
// 32-bit combinational ALU: eight functions selected by F, carry out on Cout.
// Latency: zero cycles (purely combinational).
// Backpressure: none; output follows inputs.
// Ports: F function code, A/B operands, R result, Cout carry (add carry,
// sub no-borrow, 0 for logic functions).
module Alu32bit
  import alu_pkg::*;
(
  input  logic [2:0]  F,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] R,
  output logic        Cout
);

  always_comb begin
    R    = '0;
    Cout = 1'b0;
    case (F)
      ALU_ADD:  {Cout, R} = {1'b0, A} + {1'b0, B};
      // Two's-complement subtract: carry out set means no borrow (A >= B).
      ALU_SUB:  {Cout, R} = {1'b0, A} + {1'b0, ~B} + 33'd1;
      ALU_AND:  R = A & B;
      ALU_OR:   R = A | B;
      ALU_XOR:  R = A ^ B;
      ALU_NOTA: R = ~A;
      ALU_PASS: R = A;
      ALU_NOTB: R = ~B;
      default:  R = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_fifo.sv
// Generic circular command FIFO with occupancy count and full/empty flags.
// Latency: a pushed entry is visible at head_dat one cycle after the push.
// Backpressure: caller must not push when full nor pop when empty.
// Ports: clk/rst, push/push_dat write side, pop/head_dat read side,
// count occupancy, full, empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// Buffers ALU requests, issues the head through Alu32bit into a registered result.
// Latency: request accepted at edge k is presented with out_valid after edge k+1.
// Backpressure: out_valid && !out_ready freezes result and acc; FIFO fills, in_ready drops at full.
// Ports: clk, rst (async high); in_valid/in_ready/in_f/in_a/in_b/in_chain request side;
// out_valid/out_ready/out_r/out_cout/out_zero/out_neg result side; count FIFO occupancy.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_f,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic                   in_chain,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_r,
  output logic                   out_cout,
  output logic                   out_zero,
  output logic                   out_neg,
  output logic [$clog2(DEPTH):0] count
);

  alu_cmd_t    push_cmd;
  alu_cmd_t    head_cmd;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        issue;
  logic [31:0] a_eff;
  logic [31:0] alu_r;
  logic        alu_cout;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_r_q, out_r_d;
  logic        out_cout_q, out_cout_d;
  logic        out_zero_q, out_zero_d;
  logic        out_neg_q, out_neg_d;
  logic [31:0] acc_q, acc_d;

  // in_ready depends only on registered occupancy and reset, never on out_ready.
  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  assign push_cmd = '{f: in_f, a: in_a, b: in_b, chain: in_chain};

  // Issue whenever a command is waiting and the result register is free or draining.
  assign issue = !fifo_empty && (!out_valid_q || out_ready);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(alu_cmd_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_cmd),
    .pop      (issue),
    .head_dat (head_cmd),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // acc_q tracks the last issued result, consumed or not.
  assign a_eff = head_cmd.chain ? acc_q : head_cmd.a;

  Alu32bit u_alu (
    .F    (head_cmd.f),
    .A    (a_eff),
    .B    (head_cmd.b),
    .R    (alu_r),
    .Cout (alu_cout)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_cout_d  = out_cout_q;
    out_zero_d  = out_zero_q;
    out_neg_d   = out_neg_q;
    acc_d       = acc_q;
    if (issue) begin
      out_valid_d = 1'b1;
      out_r_d     = alu_r;
      out_cout_d  = alu_cout;
      out_zero_d  = (alu_r == '0);
      out_neg_d   = alu_r[31];
      acc_d       = alu_r;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_cout_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_neg_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_cout_q  <= out_cout_d;
      out_zero_q  <= out_zero_d;
      out_neg_q   <= out_neg_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_cout  = out_cout_q;
  assign out_zero  = out_zero_q;
  assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_f = '0;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic          in_chain = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_r;
  logic          out_cout;
  logic          out_zero;
  logic          out_neg;
  logic [CW-1:0] count;

  alu_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_f      (in_f),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_chain  (in_chain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .count     (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: queue occupancy, result-register occupancy, last result,
  // and the in-order list of results still owed to the consumer.
  int          m_cnt = 0;
  bit          m_ov  = 1'b0;
  logic [31:0] m_acc = '0;
  logic [32:0] expq[$];
  logic [34:0] obs_q[$];   // {neg, zero, cout, r} as seen at consumption
  int          n_push = 0;
  int          n_both = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    case (f)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {(a >= b), a - b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {1'b0, a};
      default: return {1'b0, ~b};
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: compare DUT against the model, advance one edge, update model.
  task automatic cycle();
    bit          push, issue, cons;
    logic [31:0] a_eff;
    logic [32:0] res;
    chk("count", 64'(count), 64'(m_cnt));
    chk("in_ready", 64'(in_ready), 64'(m_cnt != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov && expq.size() > 0) begin
      chk("out_r", 64'(out_r), 64'(expq[0][31:0]));
      chk("out_cout", 64'(out_cout), 64'(expq[0][32]));
      chk("out_zero", 64'(out_zero), 64'(expq[0][31:0] == 32'h0));
      chk("out_neg", 64'(out_neg), 64'(expq[0][31]));
    end
    push  = in_valid && (m_cnt != DEPTH);
    issue = (m_cnt != 0) && (!m_ov || out_ready);
    cons  = m_ov && out_ready;
    if (cons) begin
      obs_q.push_back({out_neg, out_zero, out_cout, out_r});
      if (expq.size() > 0) void'(expq.pop_front());
    end
    if (push) begin
      a_eff = in_chain ? m_acc : in_a;
      res   = ref_op(in_f, a_eff, in_b);
      m_acc = res[31:0];
      expq.push_back(res);
      n_push++;
      if (issue) n_both++;
    end
    @(posedge clk);
    #1;
    m_cnt = m_cnt + int'(push) - int'(issue);
    if (issue) m_ov = 1'b1;
    else if (cons) m_ov = 1'b0;
  endtask

  task automatic push_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic c);
    int t = 0;
    bit took = 1'b0;
    in_f = f; in_a = a; in_b = b; in_chain = c; in_valid = 1'b1;
    do begin
      took = in_ready;
      cycle();
      t++;
    end while (!took && t < 50);
    in_valid = 1'b0;
    chk("push_accept", 64'(took), 64'(1));
  endtask

  // Drain all owed results; gap>0 inserts gap stall cycles before each accept.
  task automatic drain(input int gap, output int ncyc);
    int i = 0;
    in_valid = 1'b0;
    while (expq.size() > 0 && i < 500) begin
      out_ready = (gap == 0) || ((i % (gap + 1)) == gap);
      cycle();
      i++;
    end
    ncyc = i;
    chk("drain_done", 64'(expq.size()), 64'(0));
    chk("drain_idle", 64'(out_valid), 64'(0));
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_r"}, 64'(out_r), 64'(0));
    chk({tag, "_flags"}, 64'({out_cout, out_zero, out_neg}), 64'(0));
  endtask

  initial begin
    int n;
    int n_acc;
    int cyc;

    // Power-up reset.
    repeat (2) @(posedge clk);
    #1;
    check_zero_state("por");
    chk("por_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("por_release_in_ready", 64'(in_ready), 64'(1));

    // Mid-stream reset with 3 queued and a result held.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_req(3'($urandom_range(0, 7)), rand_word(), rand_word(), 1'b0);
    chk("pre_rst_count", 64'(count), 64'(3));
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    check_zero_state("async_rst");
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    check_zero_state("rst_held");
    rst = 1'b0;
    m_cnt = 0; m_ov = 1'b0; m_acc = '0;
    expq.delete();
    #1;
    chk("rst_release_in_ready", 64'(in_ready), 64'(1));

    // After reset: chained add sees acc=0, then plain 5+7.
    obs_q.delete();
    push_req(ALU_ADD, 32'h0, 32'h1, 1'b1);
    push_req(ALU_ADD, 32'd5, 32'd7, 1'b0);
    drain(0, n);
    chk("post_rst_n", 64'(obs_q.size()), 64'(2));
    chk("post_rst_chain", 64'(obs_q[0]), 64'({3'b000, 32'h0000_0001}));
    chk("post_rst_add", 64'(obs_q[1]), 64'({3'b000, 32'h0000_000C}));

    // Add carry / overflow into sign bit.
    obs_q.delete();
    push_req(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0);
    push_req(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
    drain(0, n);
    chk("carry_wrap", 64'(obs_q[0]), 64'({1'b0, 1'b1, 1'b1, 32'h0000_0000}));
    chk("carry_neg", 64'(obs_q[1]), 64'({1'b1, 1'b0, 1'b0, 32'h8000_0000}));

    // Chain with 3-cycle consumer stalls.
    obs_q.delete();
    out_ready = 1'b0;
    push_req(ALU_ADD, 32'd10, 32'd5, 1'b0);
    push_req(ALU_SUB, 32'hDEAD_BEEF, 32'd3, 1'b1);
    push_req(ALU_XOR, 32'h1234_5678, 32'h0000_000F, 1'b1);
    drain(3, n);
    chk("chain_n", 64'(obs_q.size()), 64'(3));
    chk("chain_0", 64'(obs_q[0]), 64'({3'b000, 32'h0000_000F}));
    chk("chain_1", 64'(obs_q[1]), 64'({3'b001, 32'h0000_000C}));
    chk("chain_2", 64'(obs_q[2]), 64'({3'b000, 32'h0000_0003}));

    // Full FIFO with output stalled: offer DEPTH+2 requests.
    obs_q.delete();
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1'b1;
      in_f = 3'($urandom_range(0, 7)); in_a = rand_word(); in_b = rand_word(); in_chain = 1'b0;
      if (in_ready) n_acc++;
      cycle();
    end
    in_valid = 1'b0;
    chk("full_accepted", 64'(n_acc), 64'(DEPTH + 1));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_count", 64'(count), 64'(DEPTH));
    drain(0, n);
    chk("full_drain_cycles", 64'(n), 64'(DEPTH + 1));
    chk("full_drain_n", 64'(obs_q.size()), 64'(DEPTH + 1));

    // Pointer wrap: 9 push/pop pairs with one entry queued.
    out_ready = 1'b0;
    push_req(ALU_OR, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
    push_req(ALU_PASS, 32'h0BAD_F00D, 32'h0, 1'b0);
    chk("wrap_start_count", 64'(count), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_f = 3'($urandom_range(0, 7)); in_a = rand_word(); in_b = rand_word();
      in_chain = ($urandom_range(0, 1) == 1);
      cycle();
      chk("wrap_count", 64'(count), 64'(1));
    end
    drain(0, n);

    // Random streaming with random handshakes.
    n_push = 0;
    n_both = 0;
    cyc = 0;
    while (n_push < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_f      = 3'($urandom_range(0, 7));
      in_a      = rand_word();
      in_b      = rand_word();
      in_chain  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      cyc++;
    end
    drain(0, n);
    chk("stream_pushes", 64'(n_push >= 1000), 64'(1));
    chk("stream_simultaneous", 64'(n_both > 0), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
